// File: rtl/phold_mc_arbiter_pkg.sv
// Shared MC message constants, slice widths and payload structs for the phold
// memory-controller arbiter.
package phold_mc_arbiter_pkg;

   localparam int unsigned RQ_CMD_W  = 3;
   localparam int unsigned RQ_SCMD_W = 4;
   localparam int unsigned VADR_W    = 48;
   localparam int unsigned SIZE_W    = 2;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned CNT_W     = 4;

   // Request commands
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_RD8  = 3'd1;
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_WR8  = 3'd2;
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_RD64 = 3'd3;
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_WR64 = 3'd4;

   // Response commands
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_RD_DATA   = 3'd2;
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_WR_CMP    = 3'd3;
   localparam logic [RQ_CMD_W-1:0] MCAE_CMD_RD64_DATA = 3'd7;

   typedef struct packed {
      logic [RQ_CMD_W-1:0]  cmd;
      logic [RQ_SCMD_W-1:0] scmd;
      logic [VADR_W-1:0]    vadr;
      logic [SIZE_W-1:0]    size;
      logic [DATA_W-1:0]    data;
   } mc_rq_payload_t;

   typedef struct packed {
      logic [RQ_CMD_W-1:0]  cmd;
      logic [RQ_SCMD_W-1:0] scmd;
      logic [DATA_W-1:0]    data;
   } mc_rs_payload_t;

endpackage

// File: rtl/phold_rr_arbiter.sv
// Generic 2**NCB-way round-robin pick: first eligible index at or above ptr,
// wrapping modulo NC. Purely combinational; the pointer lives in the parent.
module phold_rr_arbiter #(
   parameter int unsigned NCB = 2
) (
   input  logic [2**NCB-1:0] elig,
   input  logic [NCB-1:0]    ptr,
   output logic [2**NCB-1:0] gnt_oh_c,
   output logic [NCB-1:0]    gnt_idx_c,
   output logic              any_c
);

   localparam int unsigned NC = 2**NCB;

   logic [NCB-1:0] cand;

   // Walk offsets from farthest to nearest so the closest eligible index wins.
   always_comb begin
      gnt_idx_c = '0;
      any_c     = 1'b0;
      cand      = '0;
      for (int k = int'(NC) - 1; k >= 0; k--) begin
         cand = ptr + NCB'(k);
         if (elig[cand]) begin
            gnt_idx_c = cand;
            any_c     = 1'b1;
         end
      end
      gnt_oh_c = any_c ? (NC'(1) << gnt_idx_c) : '0;
   end

endmodule

// File: rtl/phold_mc_arbiter.sv
// Shares one Convey MC request/response port among 2**NCB phold cores:
// round-robin request grants, rtnctl-tag response routing, per-core outstanding limit.
module phold_mc_arbiter
   import phold_mc_arbiter_pkg::*;
#(
   parameter int unsigned NCB             = 2,
   parameter int unsigned MC_RTNCTL_WIDTH = 32,
   parameter int unsigned MAX_OUT         = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,

   input  logic [2**NCB-1:0]                     core_rq_vld,
   input  logic [RQ_CMD_W*(2**NCB)-1:0]          core_rq_cmd,
   input  logic [RQ_SCMD_W*(2**NCB)-1:0]         core_rq_scmd,
   input  logic [VADR_W*(2**NCB)-1:0]            core_rq_vadr,
   input  logic [SIZE_W*(2**NCB)-1:0]            core_rq_size,
   input  logic [MC_RTNCTL_WIDTH*(2**NCB)-1:0]   core_rq_rtnctl,
   input  logic [DATA_W*(2**NCB)-1:0]            core_rq_data,
   output logic [2**NCB-1:0]                     mem_gnt,

   output logic [2**NCB-1:0]                     core_rs_vld,
   output logic [RQ_CMD_W-1:0]                   core_rs_cmd,
   output logic [RQ_SCMD_W-1:0]                  core_rs_scmd,
   output logic [MC_RTNCTL_WIDTH-1:0]            core_rs_rtnctl,
   output logic [DATA_W-1:0]                     core_rs_data,
   input  logic [2**NCB-1:0]                     core_rs_stall,

   output logic                                  mc_rq_vld,
   output logic [RQ_CMD_W-1:0]                   mc_rq_cmd,
   output logic [RQ_SCMD_W-1:0]                  mc_rq_scmd,
   output logic [VADR_W-1:0]                     mc_rq_vadr,
   output logic [SIZE_W-1:0]                     mc_rq_size,
   output logic [MC_RTNCTL_WIDTH-1:0]            mc_rq_rtnctl,
   output logic [DATA_W-1:0]                     mc_rq_data,
   output logic                                  mc_rq_flush,
   input  logic                                  mc_rq_stall,

   input  logic                                  mc_rs_vld,
   input  logic [RQ_CMD_W-1:0]                   mc_rs_cmd,
   input  logic [RQ_SCMD_W-1:0]                  mc_rs_scmd,
   input  logic [MC_RTNCTL_WIDTH-1:0]            mc_rs_rtnctl,
   input  logic [DATA_W-1:0]                     mc_rs_data,
   output logic                                  mc_rs_stall
);

   localparam int unsigned NC = 2**NCB;
   localparam int unsigned RW = MC_RTNCTL_WIDTH;

   logic [NC-1:0]             gnt_q, gnt_d;
   logic [NCB-1:0]            ptr_q, ptr_d;
   logic [NC-1:0][CNT_W-1:0]  out_cnt_q, out_cnt_d;
   logic                      mc_rq_vld_q, mc_rq_vld_d;
   mc_rq_payload_t            rq_q, rq_d;
   logic [RW-1:0]             rq_rtnctl_q, rq_rtnctl_d;
   logic [NC-1:0]             rs_vld_q, rs_vld_d;
   mc_rs_payload_t            rs_q, rs_d;
   logic [RW-1:0]             rs_rtnctl_q, rs_rtnctl_d;

   logic [NC-1:0]             elig_c;
   logic [NC-1:0]             pick_oh_c;
   logic [NCB-1:0]            pick_idx_c;
   logic                      pick_any_c;
   mc_rq_payload_t            sel_pl_c;
   logic [RW-1:0]             sel_rtnctl_c;
   logic                      cnt_underflow_c;

   // A core just granted is masked for one cycle while its vld drops.
   always_comb begin
      elig_c = '0;
      for (int unsigned i = 0; i < NC; i++) begin
         elig_c[i] = core_rq_vld[i] && (out_cnt_q[i] < CNT_W'(MAX_OUT)) && !gnt_q[i];
      end
   end

   phold_rr_arbiter #(
      .NCB (NCB)
   ) u_rr (
      .elig      (elig_c),
      .ptr       (ptr_q),
      .gnt_oh_c  (pick_oh_c),
      .gnt_idx_c (pick_idx_c),
      .any_c     (pick_any_c)
   );

   // Mux the winner's request fields; the low rtnctl bits carry the core tag.
   always_comb begin
      sel_pl_c     = '0;
      sel_rtnctl_c = '0;
      for (int unsigned i = 0; i < NC; i++) begin
         if (pick_oh_c[i]) begin
            sel_pl_c.cmd  = core_rq_cmd[i*RQ_CMD_W +: RQ_CMD_W];
            sel_pl_c.scmd = core_rq_scmd[i*RQ_SCMD_W +: RQ_SCMD_W];
            sel_pl_c.vadr = core_rq_vadr[i*VADR_W +: VADR_W];
            sel_pl_c.size = core_rq_size[i*SIZE_W +: SIZE_W];
            sel_pl_c.data = core_rq_data[i*DATA_W +: DATA_W];
            sel_rtnctl_c  = core_rq_rtnctl[i*RW +: RW];
         end
      end
      sel_rtnctl_c[NCB-1:0] = pick_idx_c;
   end

   always_comb begin
      gnt_d       = '0;
      mc_rq_vld_d = 1'b0;
      ptr_d       = ptr_q;
      rq_d        = rq_q;
      rq_rtnctl_d = rq_rtnctl_q;
      if (!mc_rq_stall && pick_any_c) begin
         gnt_d       = pick_oh_c;
         mc_rq_vld_d = 1'b1;
         ptr_d       = pick_idx_c + NCB'(1);
         rq_d        = sel_pl_c;
         rq_rtnctl_d = sel_rtnctl_c;
      end
   end

   // Response steering by the core tag in rtnctl; payload is broadcast.
   always_comb begin
      rs_vld_d    = '0;
      rs_d        = rs_q;
      rs_rtnctl_d = rs_rtnctl_q;
      if (mc_rs_vld) begin
         rs_vld_d    = NC'(1) << mc_rs_rtnctl[NCB-1:0];
         rs_d.cmd    = mc_rs_cmd;
         rs_d.scmd   = mc_rs_scmd;
         rs_d.data   = mc_rs_data;
         rs_rtnctl_d = mc_rs_rtnctl;
      end
   end

   // Outstanding counters track issued grants against delivered responses.
   always_comb begin
      out_cnt_d       = out_cnt_q;
      cnt_underflow_c = 1'b0;
      for (int unsigned i = 0; i < NC; i++) begin
         case ({gnt_q[i], rs_vld_q[i]})
            2'b10: out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
            2'b01: begin
               if (out_cnt_q[i] != '0) begin
                  out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
               end else begin
                  cnt_underflow_c = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q       <= '0;
         ptr_q       <= '0;
         out_cnt_q   <= '0;
         mc_rq_vld_q <= 1'b0;
         rq_q        <= '0;
         rq_rtnctl_q <= '0;
         rs_vld_q    <= '0;
         rs_q        <= '0;
         rs_rtnctl_q <= '0;
      end else begin
         gnt_q       <= gnt_d;
         ptr_q       <= ptr_d;
         out_cnt_q   <= out_cnt_d;
         mc_rq_vld_q <= mc_rq_vld_d;
         rq_q        <= rq_d;
         rq_rtnctl_q <= rq_rtnctl_d;
         rs_vld_q    <= rs_vld_d;
         rs_q        <= rs_d;
         rs_rtnctl_q <= rs_rtnctl_d;
      end
   end

   // A response for a core with nothing outstanding means a lost or duplicated tag.
   a_no_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n) !cnt_underflow_c);

   assign mem_gnt        = gnt_q;
   assign mc_rq_vld      = mc_rq_vld_q;
   assign mc_rq_cmd      = rq_q.cmd;
   assign mc_rq_scmd     = rq_q.scmd;
   assign mc_rq_vadr     = rq_q.vadr;
   assign mc_rq_size     = rq_q.size;
   assign mc_rq_data     = rq_q.data;
   assign mc_rq_rtnctl   = rq_rtnctl_q;
   assign mc_rq_flush    = 1'b0;

   assign core_rs_vld    = rs_vld_q;
   assign core_rs_cmd    = rs_q.cmd;
   assign core_rs_scmd   = rs_q.scmd;
   assign core_rs_data   = rs_q.data;
   assign core_rs_rtnctl = rs_rtnctl_q;
   assign mc_rs_stall    = |core_rs_stall;

endmodule

// File: tb/tb_phold_mc_arbiter.sv
// Directed and randomized bench for phold_mc_arbiter against a cycle-level
// reference model of the grant, routing and outstanding-limit rules.
module tb_phold_mc_arbiter;
   import phold_mc_arbiter_pkg::*;

   localparam int NCB     = 2;
   localparam int NC      = 4;
   localparam int RW      = 32;
   localparam int MAX_OUT = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NC-1:0]        core_rq_vld;
   logic [3*NC-1:0]      core_rq_cmd;
   logic [4*NC-1:0]      core_rq_scmd;
   logic [48*NC-1:0]     core_rq_vadr;
   logic [2*NC-1:0]      core_rq_size;
   logic [RW*NC-1:0]     core_rq_rtnctl;
   logic [64*NC-1:0]     core_rq_data;
   logic [NC-1:0]        mem_gnt;
   logic [NC-1:0]        core_rs_vld;
   logic [2:0]           core_rs_cmd;
   logic [3:0]           core_rs_scmd;
   logic [RW-1:0]        core_rs_rtnctl;
   logic [63:0]          core_rs_data;
   logic [NC-1:0]        core_rs_stall;
   logic                 mc_rq_vld;
   logic [2:0]           mc_rq_cmd;
   logic [3:0]           mc_rq_scmd;
   logic [47:0]          mc_rq_vadr;
   logic [1:0]           mc_rq_size;
   logic [RW-1:0]        mc_rq_rtnctl;
   logic [63:0]          mc_rq_data;
   logic                 mc_rq_flush;
   logic                 mc_rq_stall;
   logic                 mc_rs_vld;
   logic [2:0]           mc_rs_cmd;
   logic [3:0]           mc_rs_scmd;
   logic [RW-1:0]        mc_rs_rtnctl;
   logic [63:0]          mc_rs_data;
   logic                 mc_rs_stall;

   // Per-core request fields, packed onto the DUT buses below
   logic [NC-1:0]  rq_vld;
   logic [2:0]     cmd_a  [NC];
   logic [3:0]     scmd_a [NC];
   logic [47:0]    vadr_a [NC];
   logic [1:0]     size_a [NC];
   logic [RW-1:0]  rtn_a  [NC];
   logic [63:0]    data_a [NC];

   always_comb begin
      core_rq_vld = rq_vld;
      for (int i = 0; i < NC; i++) begin
         core_rq_cmd[i*3 +: 3]     = cmd_a[i];
         core_rq_scmd[i*4 +: 4]    = scmd_a[i];
         core_rq_vadr[i*48 +: 48]  = vadr_a[i];
         core_rq_size[i*2 +: 2]    = size_a[i];
         core_rq_rtnctl[i*RW +: RW] = rtn_a[i];
         core_rq_data[i*64 +: 64]  = data_a[i];
      end
   end

   phold_mc_arbiter #(
      .NCB             (NCB),
      .MC_RTNCTL_WIDTH (RW),
      .MAX_OUT         (MAX_OUT)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .core_rq_vld    (core_rq_vld),
      .core_rq_cmd    (core_rq_cmd),
      .core_rq_scmd   (core_rq_scmd),
      .core_rq_vadr   (core_rq_vadr),
      .core_rq_size   (core_rq_size),
      .core_rq_rtnctl (core_rq_rtnctl),
      .core_rq_data   (core_rq_data),
      .mem_gnt        (mem_gnt),
      .core_rs_vld    (core_rs_vld),
      .core_rs_cmd    (core_rs_cmd),
      .core_rs_scmd   (core_rs_scmd),
      .core_rs_rtnctl (core_rs_rtnctl),
      .core_rs_data   (core_rs_data),
      .core_rs_stall  (core_rs_stall),
      .mc_rq_vld      (mc_rq_vld),
      .mc_rq_cmd      (mc_rq_cmd),
      .mc_rq_scmd     (mc_rq_scmd),
      .mc_rq_vadr     (mc_rq_vadr),
      .mc_rq_size     (mc_rq_size),
      .mc_rq_rtnctl   (mc_rq_rtnctl),
      .mc_rq_data     (mc_rq_data),
      .mc_rq_flush    (mc_rq_flush),
      .mc_rq_stall    (mc_rq_stall),
      .mc_rs_vld      (mc_rs_vld),
      .mc_rs_cmd      (mc_rs_cmd),
      .mc_rs_scmd     (mc_rs_scmd),
      .mc_rs_rtnctl   (mc_rs_rtnctl),
      .mc_rs_data     (mc_rs_data),
      .mc_rs_stall    (mc_rs_stall)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int            ptr_m;
   int            cnt_m [NC];
   int            pend  [NC];
   logic [NC-1:0] exp_gnt, exp_rs;
   logic          exp_vld;
   logic [47:0]   e_vadr;
   logic [2:0]    e_cmd;
   logic [63:0]   e_rq_data, e_rs_data;
   logic [RW-1:0] e_rtn;
   logic [2:0]    e_rs_cmd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ptr_m   = 0;
      exp_gnt = '0;
      exp_rs  = '0;
      exp_vld = 1'b0;
      for (int i = 0; i < NC; i++) begin
         cnt_m[i] = 0;
         pend[i]  = 0;
      end
   endtask

   // Predict the next registered outputs from the inputs now driven, clock once, compare.
   task automatic cycle();
      int g;
      logic [NC-1:0] elig;
      g = -1;
      for (int i = 0; i < NC; i++)
         elig[i] = rq_vld[i] && (cnt_m[i] < MAX_OUT) && !exp_gnt[i];
      if (!mc_rq_stall)
         for (int k = 0; k < NC; k++)
            if (g < 0 && elig[(ptr_m + k) % NC]) g = (ptr_m + k) % NC;
      for (int i = 0; i < NC; i++) begin
         cnt_m[i] = cnt_m[i] + int'(exp_gnt[i]) - int'(exp_rs[i]);
         if (cnt_m[i] < 0) cnt_m[i] = 0;
      end
      exp_vld = (g >= 0);
      exp_gnt = '0;
      if (g >= 0) begin
         exp_gnt[g] = 1'b1;
         ptr_m      = (g + 1) % NC;
         e_vadr     = vadr_a[g];
         e_cmd      = cmd_a[g];
         e_rq_data  = data_a[g];
         e_rtn      = rtn_a[g];
         e_rtn[NCB-1:0] = NCB'(g);
      end
      exp_rs = '0;
      if (mc_rs_vld) begin
         exp_rs[mc_rs_rtnctl[NCB-1:0]] = 1'b1;
         e_rs_data = mc_rs_data;
         e_rs_cmd  = mc_rs_cmd;
      end
      @(posedge clk);
      @(negedge clk);
      chk("mem_gnt", 64'(mem_gnt), 64'(exp_gnt));
      chk("mc_rq_vld", 64'(mc_rq_vld), 64'(exp_vld));
      chk("mc_rq_flush", 64'(mc_rq_flush), 64'd0);
      if (exp_vld) begin
         chk("mc_rq_vadr", 64'(mc_rq_vadr), 64'(e_vadr));
         chk("mc_rq_rtnctl", 64'(mc_rq_rtnctl), 64'(e_rtn));
         chk("mc_rq_cmd", 64'(mc_rq_cmd), 64'(e_cmd));
         chk("mc_rq_data", mc_rq_data, e_rq_data);
      end
      chk("core_rs_vld", 64'(core_rs_vld), 64'(exp_rs));
      if (|exp_rs) begin
         chk("core_rs_data", core_rs_data, e_rs_data);
         chk("core_rs_cmd", 64'(core_rs_cmd), 64'(e_rs_cmd));
      end
      chk("mc_rs_stall", 64'(mc_rs_stall), 64'(|core_rs_stall));
      for (int i = 0; i < NC; i++) if (exp_gnt[i]) pend[i]++;
   endtask

   task automatic set_req(input int i, input logic [2:0] cmd, input logic [47:0] vadr);
      rq_vld[i] = 1'b1;
      cmd_a[i]  = cmd;
      scmd_a[i] = 4'($urandom);
      vadr_a[i] = vadr;
      size_a[i] = 2'($urandom);
      rtn_a[i]  = RW'($urandom);
      data_a[i] = {$urandom, $urandom};
   endtask

   task automatic send_rsp(input int j, input logic [2:0] cmd, input logic [63:0] data);
      logic [RW-1:0] r;
      r = RW'($urandom);
      r[NCB-1:0] = NCB'(j);
      mc_rs_vld    = 1'b1;
      mc_rs_cmd    = cmd;
      mc_rs_scmd   = 4'($urandom);
      mc_rs_rtnctl = r;
      mc_rs_data   = data;
      pend[j]--;
   endtask

   task automatic drain();
      for (int j = 0; j < NC; j++)
         while (pend[j] > 0) begin
            send_rsp(j, MCAE_CMD_RD_DATA, 64'(j + 100));
            cycle();
         end
      mc_rs_vld = 1'b0;
      repeat (3) cycle();
      chk("drain_cnt", 64'(dut.out_cnt_q), 64'd0);
   endtask

   initial begin
      int n;
      logic found;
      logic [NC-1:0] gseq [5];

      rst_n = 1'b0;
      rq_vld = '0;
      core_rs_stall = '0;
      mc_rq_stall = 1'b0;
      mc_rs_vld = 1'b0;
      mc_rs_cmd = '0;
      mc_rs_scmd = '0;
      mc_rs_rtnctl = '0;
      mc_rs_data = '0;
      for (int i = 0; i < NC; i++) begin
         cmd_a[i] = '0; scmd_a[i] = '0; vadr_a[i] = '0;
         size_a[i] = '0; rtn_a[i] = '0; data_a[i] = '0;
      end
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_mem_gnt", 64'(mem_gnt), 64'd0);
      chk("rst_mc_rq_vld", 64'(mc_rq_vld), 64'd0);
      chk("rst_core_rs_vld", 64'(core_rs_vld), 64'd0);
      chk("rst_mc_rq_vadr", 64'(mc_rq_vadr), 64'd0);
      chk("rst_core_rs_data", core_rs_data, 64'd0);
      chk("rst_out_cnt", 64'(dut.out_cnt_q), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_mem_gnt", 64'(mem_gnt), 64'd0);

      // Single core 3 read
      set_req(3, MCAE_CMD_RD8, 48'hf0f0);
      cycle();
      chk("t1_gnt", 64'(mem_gnt), 64'b1000);
      chk("t1_vld", 64'(mc_rq_vld), 64'd1);
      chk("t1_vadr", 64'(mc_rq_vadr), 64'hf0f0);
      chk("t1_rtn_idx", 64'(mc_rq_rtnctl[1:0]), 64'd3);
      rq_vld = '0;
      repeat (2) cycle();

      // All cores requesting: strict rotation, no back-to-back grants
      for (int i = 0; i < NC; i++) set_req(i, MCAE_CMD_RD8, 48'({$urandom, $urandom}));
      for (int c = 0; c < 5; c++) begin
         cycle();
         gseq[c] = mem_gnt;
      end
      rq_vld = '0;
      cycle();
      chk("t2_g0", 64'(gseq[0]), 64'b0001);
      chk("t2_g1", 64'(gseq[1]), 64'b0010);
      chk("t2_g2", 64'(gseq[2]), 64'b0100);
      chk("t2_g3", 64'(gseq[3]), 64'b1000);
      chk("t2_g4", 64'(gseq[4]), 64'b0001);

      // MC stall holds off a pending core 1
      set_req(1, MCAE_CMD_WR8, 48'h1234);
      mc_rq_stall = 1'b1;
      repeat (3) begin
         cycle();
         chk("t3_stall_gnt", 64'(mem_gnt), 64'd0);
         chk("t3_stall_vld", 64'(mc_rq_vld), 64'd0);
      end
      mc_rq_stall = 1'b0;
      cycle();
      chk("t3_gnt_after_stall", 64'(mem_gnt), 64'b0010);
      rq_vld = '0;
      cycle();

      // Write completion routed to core 2
      send_rsp(2, MCAE_CMD_WR_CMP, 64'hf0f0);
      cycle();
      chk("t4_rs_vld", 64'(core_rs_vld), 64'b0100);
      chk("t4_rs_data", core_rs_data, 64'hf0f0);
      chk("t4_rs_cmd", 64'(core_rs_cmd), 64'(MCAE_CMD_WR_CMP));
      mc_rs_vld = 1'b0;
      cycle();
      chk("t4_cnt2", 64'(dut.out_cnt_q[2]), 64'd0);
      drain();

      // Outstanding limit on core 0
      set_req(0, MCAE_CMD_RD8, 48'h40);
      n = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         if (mem_gnt[0]) n++;
      end
      chk("t5_grants", 64'(n), 64'd4);
      chk("t5_cnt0", 64'(dut.out_cnt_q[0]), 64'd4);
      send_rsp(0, MCAE_CMD_RD_DATA, 64'h55);
      cycle();
      mc_rs_vld = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
         cycle();
         if (mem_gnt[0]) found = 1'b1;
      end
      chk("t5_regrant", 64'(found), 64'd1);
      rq_vld = '0;
      cycle();
      drain();

      // Grant and response to core 1 in the same cycle
      set_req(1, MCAE_CMD_RD8, 48'h80);
      cycle();
      rq_vld = '0;
      cycle();
      set_req(1, MCAE_CMD_RD8, 48'h88);
      send_rsp(1, MCAE_CMD_RD_DATA, 64'h77);
      cycle();
      chk("t6_gnt", 64'(mem_gnt), 64'b0010);
      chk("t6_rs", 64'(core_rs_vld), 64'b0010);
      rq_vld = '0;
      mc_rs_vld = 1'b0;
      cycle();
      chk("t6_cnt1", 64'(dut.out_cnt_q[1]), 64'd1);
      core_rs_stall = 4'b0010;
      #1;
      chk("t6_rs_stall_hi", 64'(mc_rs_stall), 64'd1);
      core_rs_stall = '0;
      #1;
      chk("t6_rs_stall_lo", 64'(mc_rs_stall), 64'd0);
      drain();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         int j;
         for (int i = 0; i < NC; i++) begin
            if (exp_gnt[i]) rq_vld[i] = 1'b0;
            else if (!rq_vld[i] && ($urandom_range(0, 2) == 0))
               set_req(i, 3'($urandom_range(1, 4)), 48'({$urandom, $urandom}));
         end
         mc_rq_stall   = ($urandom_range(0, 4) == 0);
         core_rs_stall = NC'($urandom_range(0, 3) == 0 ? $urandom : 0);
         mc_rs_vld     = 1'b0;
         j = int'($urandom_range(0, NC - 1));
         if (pend[j] > 0 && $urandom_range(0, 1) == 1)
            send_rsp(j, 3'($urandom), {$urandom, $urandom});
         cycle();
      end

      // Reset with requests outstanding clears the counters
      rq_vld = '0;
      mc_rs_vld = 1'b0;
      mc_rq_stall = 1'b0;
      core_rs_stall = '0;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", 64'(dut.out_cnt_q), 64'd0);
      chk("mid_rst_gnt", 64'(mem_gnt), 64'd0);
      chk("mid_rst_rs_vld", 64'(core_rs_vld), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      set_req(2, MCAE_CMD_RD64, 48'habc0);
      cycle();
      chk("post_mid_rst_gnt", 64'(mem_gnt), 64'b0100);
      rq_vld = '0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
